// File: rtl/lsu_dmem.sv
// Load/store unit: aligns byte lanes, runs a valid/ready request to data memory and
// extends load data. Optional misaligned-access trap enabled by LSU_MISALIGN_TRAP_EN.
module lsu_dmem #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [3:0]        i_mask,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_load_data,
    output logic              o_misaligned,
    output logic              o_dmem_req,
    input  logic              i_dmem_ready,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic              o_dmem_wen,
    output logic [3:0]        o_dmem_mask,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic                req_q;
    logic                done_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          mask_q;
    logic [31:0]         wdata_q;
    logic [31:0]         load_data_q;
    logic [1:0]          off_q;
    logic [2:0]          funct3_q;

    logic                accept;
    logic                is_byte;
    logic                is_half;
    logic [1:0]          off_d;
    logic [3:0]          mask_d;
    logic [31:0]         wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                trap_d;
    logic [7:0]          rbyte;
    logic [15:0]         rhalf;
    logic [31:0]         load_ext_d;

    assign accept = (state_q == ST_IDLE) && i_valid && (i_mem_read || i_mem_write);

    // Reset also forces the stall low so every output reads 0 while reset is held.
    assign o_stall = i_rst_n && (accept || (state_q == ST_REQ) || (state_q == ST_RSP));

    assign is_byte = (i_funct3[1:0] == 2'b00);
    assign is_half = (i_funct3[1:0] == 2'b01);
    assign addr_d  = {i_addr[ADDR_W-1:2], 2'b00};

    // Halves drop addr[0] and words drop addr[1:0] so the lane offset is always legal.
    always_comb begin
        off_d   = 2'b00;
        wdata_d = i_wdata;
        if (is_byte) begin
            off_d   = i_addr[1:0];
            wdata_d = {4{i_wdata[7:0]}};
        end else if (is_half) begin
            off_d   = {i_addr[1], 1'b0};
            wdata_d = {2{i_wdata[15:0]}};
        end
    end

    assign mask_d = i_mask << off_d;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_d = (is_half && i_addr[0]) || (!is_byte && !is_half && (i_addr[1:0] != 2'b00));
`else
    assign trap_d = 1'b0;
`endif

    always_comb begin
        rbyte = i_dmem_rdata[7:0];
        case (off_q)
            2'd0: rbyte = i_dmem_rdata[7:0];
            2'd1: rbyte = i_dmem_rdata[15:8];
            2'd2: rbyte = i_dmem_rdata[23:16];
            2'd3: rbyte = i_dmem_rdata[31:24];
            default: rbyte = i_dmem_rdata[7:0];
        endcase
    end

    assign rhalf = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

    always_comb begin
        load_ext_d = i_dmem_rdata;
        case (funct3_q)
            3'b000:  load_ext_d = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_ext_d = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_ext_d = {24'd0, rbyte};
            3'b101:  load_ext_d = {16'd0, rhalf};
            default: load_ext_d = i_dmem_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= accept && trap_d;
        end
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            mask_q      <= 4'b0000;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (trap_d) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            load_data_q <= 32'd0;
                        end else begin
                            state_q  <= ST_REQ;
                            req_q    <= 1'b1;
                            wen_q    <= i_mem_write && !i_mem_read;
                            addr_q   <= addr_d;
                            mask_q   <= mask_d;
                            wdata_q  <= wdata_d;
                            off_q    <= off_d;
                            funct3_q <= i_funct3;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_dmem_ready) begin
                        req_q <= 1'b0;
                        if (wen_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (i_dmem_rvalid) begin
                        load_data_q <= load_ext_d;
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_done       = done_q;
    assign o_load_data  = load_data_q;
    assign o_dmem_req   = req_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wen   = wen_q;
    assign o_dmem_mask  = mask_q;
    assign o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed testbench for lsu_dmem: vector table for aligned accesses plus hand-written
// sequences for back-pressure, reset mid-access, misalignment and accept timing.
module tb_lsu_dmem;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [3:0]  i_mask;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic        o_dmem_req;
    logic        i_dmem_ready;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_wen;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int tests = 0;
    int fails = 0;

    lsu_dmem #(.ADDR_W(32)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_funct3      (i_funct3),
        .i_mask        (i_mask),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_done        (o_done),
        .o_load_data   (o_load_data),
        .o_misaligned  (o_misaligned),
        .o_dmem_req    (o_dmem_req),
        .i_dmem_ready  (i_dmem_ready),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_mask   (o_dmem_mask),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  f3;
        logic [3:0]  mask;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic        e_wen;
        logic [31:0] e_load;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic [2:0] f3, input logic [3:0] mask, input logic rd,
                                input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [31:0] e_addr,
                                input logic [3:0] e_mask, input logic [31:0] e_wdata,
                                input logic e_wen, input logic [31:0] e_load);
        vec_t v;
        v.f3 = f3;       v.mask = mask;     v.rd = rd;           v.wr = wr;
        v.addr = addr;   v.wdata = wdata;   v.rdata = rdata;     v.e_addr = e_addr;
        v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_wen = e_wen; v.e_load = e_load;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [3:0] mask, input logic [31:0] addr,
                            input logic [31:0] wdata);
        i_valid     = 1'b1;
        i_mem_read  = rd;
        i_mem_write = wr;
        i_funct3    = f3;
        i_mask      = mask;
        i_addr      = addr;
        i_wdata     = wdata;
    endtask

    task automatic idle_op();
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    // Zero-wait memory; rvalid is also pulsed with junk during REQ, where it must be ignored.
    task automatic apply_vec(input vec_t v, input int idx);
        tick();
        drive_op(v.rd, v.wr, v.f3, v.mask, v.addr, v.wdata);
        i_dmem_ready  = 1'b1;
        i_dmem_rvalid = 1'b0;
        mid();
        chk($sformatf("v%0d c0 stall", idx), o_stall, 1);
        chk($sformatf("v%0d c0 req", idx), o_dmem_req, 0);
        tick();
        idle_op();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hA5A5_A5A5;
        mid();
        chk($sformatf("v%0d c1 req", idx), o_dmem_req, 1);
        chk($sformatf("v%0d c1 addr", idx), o_dmem_addr, v.e_addr);
        chk($sformatf("v%0d c1 mask", idx), o_dmem_mask, v.e_mask);
        chk($sformatf("v%0d c1 wdata", idx), o_dmem_wdata, v.e_wdata);
        chk($sformatf("v%0d c1 wen", idx), o_dmem_wen, v.e_wen);
        chk($sformatf("v%0d c1 stall", idx), o_stall, 1);
        chk($sformatf("v%0d c1 done", idx), o_done, 0);
        tick();
        i_dmem_rvalid = !v.e_wen;
        i_dmem_rdata  = v.rdata;
        mid();
        if (v.e_wen) begin
            chk($sformatf("v%0d c2 done", idx), o_done, 1);
            chk($sformatf("v%0d c2 stall", idx), o_stall, 0);
            chk($sformatf("v%0d c2 held load", idx), o_load_data, v.e_load);
        end else begin
            chk($sformatf("v%0d c2 done", idx), o_done, 0);
            chk($sformatf("v%0d c2 req", idx), o_dmem_req, 0);
            chk($sformatf("v%0d c2 stall", idx), o_stall, 1);
            tick();
            i_dmem_rvalid = 1'b0;
            mid();
            chk($sformatf("v%0d c3 done", idx), o_done, 1);
            chk($sformatf("v%0d c3 load", idx), o_load_data, v.e_load);
            chk($sformatf("v%0d c3 stall", idx), o_stall, 0);
        end
        tick();
        i_dmem_rvalid = 1'b0;
        mid();
        chk($sformatf("v%0d after done", idx), o_done, 0);
        chk($sformatf("v%0d after req", idx), o_dmem_req, 0);
        $display("[TB] vec %0d f3=%b rd=%0b wr=%0b addr=%h -> mask=%b wdata=%h load=%h",
                 idx, v.f3, v.rd, v.wr, v.addr, o_dmem_mask, o_dmem_wdata, o_load_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //              f3      mask     rd wr addr          wdata         rdata         e_addr        e_mask   e_wdata       wen e_load
        vecs[0] = mk(3'b000, 4'b0001, 0, 1, 32'h0000_1003, 32'h0000_00AB, 32'h0,        32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1, 32'h0);
        vecs[1] = mk(3'b000, 4'b0001, 1, 0, 32'h0000_2001, 32'h0,        32'h0000_8000, 32'h0000_2000, 4'b0010, 32'h0,        0, 32'hFFFF_FF80);
        vecs[2] = mk(3'b100, 4'b0001, 1, 0, 32'h0000_2001, 32'h0,        32'h0000_8000, 32'h0000_2000, 4'b0010, 32'h0,        0, 32'h0000_0080);
        vecs[3] = mk(3'b001, 4'b0011, 0, 1, 32'h0000_2002, 32'h1234_5678, 32'h0,        32'h0000_2000, 4'b1100, 32'h5678_5678, 1, 32'h0000_0080);
        vecs[4] = mk(3'b001, 4'b0011, 1, 0, 32'h0000_2000, 32'h0,        32'h1234_F00D, 32'h0000_2000, 4'b0011, 32'h0,        0, 32'hFFFF_F00D);
        vecs[5] = mk(3'b010, 4'b1111, 1, 0, 32'h0000_2004, 32'h0,        32'hDEAD_BEEF, 32'h0000_2004, 4'b1111, 32'h0,        0, 32'hDEAD_BEEF);
        vecs[6] = mk(3'b010, 4'b1111, 0, 1, 32'h0000_2008, 32'hCAFE_F00D, 32'h0,        32'h0000_2008, 4'b1111, 32'hCAFE_F00D, 1, 32'hDEAD_BEEF);
        vecs[7] = mk(3'b010, 4'b1111, 1, 1, 32'h0000_200C, 32'h1111_1111, 32'h8765_4321, 32'h0000_200C, 4'b1111, 32'h1111_1111, 0, 32'h8765_4321);
        vecs[8] = mk(3'b000, 4'b0001, 1, 0, 32'h0000_2003, 32'h0,        32'h7F00_0000, 32'h0000_2000, 4'b1000, 32'h0,        0, 32'h0000_007F);

        i_rst_n       = 1'b0;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'h0;
        drive_op(1'b1, 1'b0, 3'b010, 4'b1111, 32'h0, 32'h0);
        repeat (2) tick();
        mid();
        chk("reset stall", o_stall, 0);
        chk("reset req", o_dmem_req, 0);
        chk("reset done", o_done, 0);
        chk("reset misaligned", o_misaligned, 0);
        chk("reset mask", o_dmem_mask, 0);
        chk("reset addr", o_dmem_addr, 0);
        chk("reset wdata", o_dmem_wdata, 0);
        chk("reset load", o_load_data, 0);
        chk("reset wen", o_dmem_wen, 0);
        idle_op();
        i_rst_n = 1'b1;

        for (int k = 0; k < 9; k++) apply_vec(vecs[k], k);

        // LHU under back-pressure: ready low for 3 cycles, rvalid two cycles after handshake.
        tick();
        drive_op(1'b1, 1'b0, 3'b101, 4'b0011, 32'h0000_3002, 32'h0);
        i_dmem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            idle_op();
            i_dmem_ready = (c == 4);
            mid();
            chk($sformatf("bp c%0d req", c), o_dmem_req, 1);
            chk($sformatf("bp c%0d addr", c), o_dmem_addr, 32'h0000_3000);
            chk($sformatf("bp c%0d mask", c), o_dmem_mask, 4'b1100);
            chk($sformatf("bp c%0d wdata", c), o_dmem_wdata, 32'h0);
            chk($sformatf("bp c%0d stall", c), o_stall, 1);
        end
        tick();
        i_dmem_ready = 1'b0;
        mid();
        chk("bp c5 req", o_dmem_req, 0);
        chk("bp c5 stall", o_stall, 1);
        tick();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hBEEF_1234;
        mid();
        chk("bp c6 done", o_done, 0);
        tick();
        i_dmem_rvalid = 1'b0;
        mid();
        chk("bp c7 done", o_done, 1);
        chk("bp c7 load", o_load_data, 32'h0000_BEEF);
        $display("[TB] LHU back-pressure addr=00003002 load=%h", o_load_data);
        tick();

        // LW with reset asserted while waiting in RSP; late rvalid must be ignored.
        tick();
        drive_op(1'b1, 1'b0, 3'b010, 4'b1111, 32'h0000_5000, 32'h0);
        i_dmem_ready = 1'b1;
        tick();
        idle_op();
        tick();
        mid();
        chk("rst pre stall", o_stall, 1);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("rst req", o_dmem_req, 0);
        chk("rst stall", o_stall, 0);
        chk("rst done", o_done, 0);
        chk("rst load", o_load_data, 0);
        chk("rst addr", o_dmem_addr, 0);
        chk("rst mask", o_dmem_mask, 0);
        mid();
        i_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            i_dmem_rvalid = (c == 0);
            i_dmem_rdata  = 32'h1357_9BDF;
            mid();
            chk($sformatf("rst late c%0d done", c), o_done, 0);
            chk($sformatf("rst late c%0d load", c), o_load_data, 0);
        end
        i_dmem_rvalid = 1'b0;
        $display("[TB] LW reset mid-access, late rvalid done=%0b", o_done);

        // Misaligned LW at 0x4002.
        tick();
        drive_op(1'b1, 1'b0, 3'b010, 4'b1111, 32'h0000_4002, 32'h0);
        i_dmem_ready = 1'b1;
        mid();
        chk("mis c0 stall", o_stall, 1);
        tick();
        idle_op();
`ifdef LSU_MISALIGN_TRAP_EN
        mid();
        chk("mis c1 req", o_dmem_req, 0);
        chk("mis c1 done", o_done, 1);
        chk("mis c1 misaligned", o_misaligned, 1);
        chk("mis c1 load", o_load_data, 0);
        tick();
        mid();
        chk("mis c2 req", o_dmem_req, 0);
        chk("mis c2 done", o_done, 0);
        chk("mis c2 misaligned", o_misaligned, 0);
`else
        mid();
        chk("mis c1 req", o_dmem_req, 1);
        chk("mis c1 addr", o_dmem_addr, 32'h0000_4000);
        chk("mis c1 mask", o_dmem_mask, 4'b1111);
        chk("mis c1 misaligned", o_misaligned, 0);
        tick();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h0BAD_F00D;
        tick();
        i_dmem_rvalid = 1'b0;
        mid();
        chk("mis c3 done", o_done, 1);
        chk("mis c3 load", o_load_data, 32'h0BAD_F00D);
        chk("mis c3 misaligned", o_misaligned, 0);
`endif
        $display("[TB] misaligned LW addr=00004002 load=%h", o_load_data);
        tick();

        // Valid without a memory op is ignored.
        tick();
        drive_op(1'b0, 1'b0, 3'b010, 4'b1111, 32'h0000_7000, 32'h0);
        mid();
        chk("nop c0 stall", o_stall, 0);
        tick();
        mid();
        chk("nop c1 req", o_dmem_req, 0);
        chk("nop c1 stall", o_stall, 0);
        idle_op();
        $display("[TB] non-memory valid stall=%0b req=%0b", o_stall, o_dmem_req);

        // Back-to-back loads: second presented during DONE must wait one cycle.
        tick();
        drive_op(1'b1, 1'b0, 3'b010, 4'b1111, 32'h0000_6000, 32'h0);
        i_dmem_ready = 1'b1;
        tick();
        tick();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h1122_3344;
        tick();
        i_dmem_rvalid = 1'b0;
        drive_op(1'b1, 1'b0, 3'b010, 4'b1111, 32'h0000_6004, 32'h0);
        mid();
        chk("b2b c3 done", o_done, 1);
        chk("b2b c3 stall", o_stall, 0);
        chk("b2b c3 load", o_load_data, 32'h1122_3344);
        tick();
        mid();
        chk("b2b c4 stall", o_stall, 1);
        chk("b2b c4 req", o_dmem_req, 0);
        chk("b2b c4 done", o_done, 0);
        tick();
        idle_op();
        mid();
        chk("b2b c5 req", o_dmem_req, 1);
        chk("b2b c5 addr", o_dmem_addr, 32'h0000_6004);
        tick();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h5566_7788;
        tick();
        i_dmem_rvalid = 1'b0;
        mid();
        chk("b2b c7 done", o_done, 1);
        chk("b2b c7 load", o_load_data, 32'h5566_7788);
        $display("[TB] back-to-back LW second load=%h", o_load_data);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
